// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data-RAM port arbiter.
// Optional feature macro: MEM_ARB_RR_EN (round-robin tie-break).
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    localparam logic REQ_IF  = 1'b0;
    localparam logic REQ_MEM = 1'b1;

    localparam int LATENCY_DEF = 2;
    localparam int CNT_W       = 3;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between IF and MEM requesters.
// MEM_ARB_RR_EN: ties go to the requester not served last.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] reqs,
    input  logic       last_owner,
    input  logic [1:0] excl,
    output logic       gnt_id,
    output logic       gnt_vld
);

    logic [1:0] elig;

    assign elig    = reqs & ~excl;
    assign gnt_vld = |elig;

`ifdef MEM_ARB_RR_EN
    always_comb begin
        gnt_id = REQ_IF;
        if (&elig) begin
            gnt_id = ~last_owner;
        end else if (elig[REQ_MEM]) begin
            gnt_id = REQ_MEM;
        end
    end
`else
    logic unused_last_owner;

    assign unused_last_owner = last_owner;
    assign gnt_id = elig[REQ_MEM] ? REQ_MEM : REQ_IF;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the data RAM between IF and MEM with a sequenced multi-cycle access.
// Optional feature macro: MEM_ARB_RR_EN (round-robin tie-break in IDLE).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LATENCY = LATENCY_DEF,
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_ack,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_stall,
    output logic              ram_rd,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             owner;
    logic             last_owner;
    logic             we_r;
    logic             gnt_id;
    logic             gnt_vld;
    logic             gnt_we;
    logic [1:0]       excl;

    // The requester just acked may still hold req in DONE.
    assign excl   = (state == DONE) ? (2'b01 << owner) : 2'b00;
    assign gnt_we = (gnt_id == REQ_MEM) & mem_we;

    assign if_stall  = if_req & ~if_ack;
    assign mem_stall = mem_req & ~mem_ack;

    mem_arb_pick u_pick (
        .reqs       ({mem_req, if_req}),
        .last_owner (last_owner),
        .excl       (excl),
        .gnt_id     (gnt_id),
        .gnt_vld    (gnt_vld)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            owner      <= REQ_MEM;
            last_owner <= REQ_IF;
            we_r       <= 1'b0;
            ram_rd     <= 1'b0;
            ram_wr     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            if_ack     <= 1'b0;
            mem_ack    <= 1'b0;
            if_rdata   <= '0;
            mem_rdata  <= '0;
        end else begin
            if_ack  <= 1'b0;
            mem_ack <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    ram_rd <= 1'b0;
                    ram_wr <= 1'b0;
                    state  <= IDLE;
                    if (gnt_vld) begin
                        state      <= ACCESS;
                        owner      <= gnt_id;
                        last_owner <= gnt_id;
                        we_r       <= gnt_we;
                        ram_rd     <= ~gnt_we;
                        ram_wr     <= gnt_we;
                        cnt        <= CNT_INIT;
                        if (gnt_id == REQ_MEM) begin
                            ram_addr  <= mem_addr;
                            ram_wdata <= mem_wdata;
                        end else begin
                            ram_addr  <= if_addr;
                            ram_wdata <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        ram_rd <= 1'b0;
                        ram_wr <= 1'b0;
                        state  <= DONE;
                        if (owner == REQ_MEM) begin
                            mem_ack <= 1'b1;
                            if (!we_r) begin
                                mem_rdata <= ram_rdata;
                            end
                        end else begin
                            if_ack   <= 1'b1;
                            if_rdata <= ram_rdata;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 512x32 data RAM between two requesters: instruction fetch (IF) and the Memory stage (MEM).
- Multi-cycle FSM sequences each RAM access and returns read data with a one-cycle ack pulse.
- Drives per-requester stall outputs so the pipeline freezes while a requester waits.
- Sits between the IF/Memory stages and the Ram instance; the tristate data-bus adaptation to Ram lives outside this block.

Parameters:
- LATENCY, 2, RAM access cycles per transfer; legal range 1..7.
- ADDR_W, 9, RAM word-address width.
- DATA_W, 32, data width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  IF access request, read-only.
- if_addr  in  ADDR_W  IF word address.
- if_ack  out  1  one-cycle pulse: if_rdata valid.
- if_rdata  out  DATA_W  IF read data, registered.
- if_stall  out  1  if_req & ~if_ack.
- mem_req  in  1  MEM access request.
- mem_we  in  1  1 = write, 0 = read.
- mem_addr  in  ADDR_W  MEM word address.
- mem_wdata  in  DATA_W  MEM write data.
- mem_ack  out  1  one-cycle pulse: access complete, mem_rdata valid on reads.
- mem_rdata  out  DATA_W  MEM read data, registered.
- mem_stall  out  1  mem_req & ~mem_ack.
- ram_rd  out  1  RAM read enable.
- ram_wr  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data.

Behaviour:
- Clock and reset: clock rising edge; reset asynchronous, active-low (reset=0 resets immediately).
- Reset values: state=IDLE; all acks, ram_rd, ram_wr = 0; ram_addr, ram_wdata, if_rdata, mem_rdata, cnt = 0; owner=MEM.
- Reset mid-access: transfer abandoned and no ack issued; ram_wr drops asynchronously.
- Requester rule: hold req, addr, we and wdata stable until the ack cycle. The arbiter latches them at grant and does not re-sample them.
- FSM states: IDLE, ACCESS, DONE.
- IDLE: any req -> latch the winner's address/we/wdata into RAM-side registers, set owner, cnt=LATENCY-1, go to ACCESS. No req -> stay.
- ACCESS: ram_rd=~we, ram_wr=we, held constant for all LATENCY cycles.
  - cnt decrements each cycle.
  - At cnt==0: capture ram_rdata into the owner's rdata register (reads only), then go to DONE.
- DONE: owner's ack=1 for exactly one cycle; RAM enables are 0.
  - The other requester pending -> grant it directly (DONE->ACCESS, no IDLE bubble).
  - Otherwise -> IDLE.
  - The just-served requester is ineligible in DONE, since its req may still be high from the ack cycle.
- Latency: req rising in IDLE at cycle 0 -> ACCESS cycles 1..LATENCY -> ack in cycle LATENCY+1.
- Throughput: under contention, one transfer per LATENCY+1 cycles.
- Arbitration when both request in IDLE: MEM wins (fixed priority; the older instruction goes first).
- Write: mem_rdata is left unchanged; mem_ack still pulses.
- if_rdata and mem_rdata hold their value until the next capture for that requester.
- cnt width: 3 bits.

Optional Feature:
- MEM_ARB_RR_EN defined: simultaneous requests in IDLE go to the requester not served last (round-robin via a last_owner flag; reset value of last_owner = IF, so MEM wins first).
- MEM_ARB_RR_EN undefined: fixed MEM priority as above.
- DONE-state handoff behaviour is identical in both builds.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state enum: IDLE, ACCESS, DONE.
  - requester id constants: REQ_IF=0, REQ_MEM=1.
  - default LATENCY.
- One sub-module, mem_arb_pick: combinational winner select (inputs: reqs, last_owner, exclude mask; output: grant id + valid). It contains the MEM_ARB_RR_EN variant.

Test Plan:
- Single IF read: LATENCY=2, RAM[0x010]=0xDEADBEEF, if_req at cycle 0 -> ram_rd=1 in cycles 1-2, if_ack and if_rdata=0xDEADBEEF in cycle 3, if_stall=1 in cycles 0-2.
- MEM write then read: write 0x12345678 to 0x1FF -> mem_ack at cycle 3, ram_wr=1 only in cycles 1-2. Next read of 0x1FF -> mem_rdata=0x12345678.
- Contention: if_req and mem_req both at cycle 0:
  - MEM served first, mem_ack at cycle 3.
  - IF granted from DONE, if_ack at cycle 6.
  - if_stall high in cycles 0-5.
- Round-robin (MEM_ARB_RR_EN, both requesters hold req continuously): grants alternate MEM, IF, MEM, IF; no requester is served twice in a row.
- Reset mid-access: reset=0 during ACCESS cycle 1 -> ram_wr=0 immediately, state IDLE, no ack. Re-request completes normally.
- LATENCY=1: ack two cycles after req. Back-to-back MEM reads of 0x000 and 0x001 (mem_req held) -> acks 3 cycles apart.
